// File: rtl/vicmidi_pkg.sv
// Shared definitions for the MIDI receive FIFO: receiver FSM states,
// register window addresses and status/control bit positions.
package vicmidi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_e;

    // Register window addresses
    localparam logic REG_DATA = 1'b0;
    localparam logic REG_STAT = 1'b1;

    // STATUS read bit positions
    localparam int STAT_NE      = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_OVR     = 2;
    localparam int STAT_FERR    = 3;
    localparam int STAT_CNT_LSB = 4;
    localparam int STAT_IEN     = 7;

    // CONTROL write bit positions
    localparam int CTRL_CLR_OVR  = 2;
    localparam int CTRL_CLR_FERR = 3;
    localparam int CTRL_FLUSH    = 6;
    localparam int CTRL_IEN      = 7;

endpackage

// File: rtl/midi_fifo.sv
// Small synchronous FIFO holding received MIDI bytes. Flush overrides any
// push/pop in the same cycle; a pop on empty is ignored; a push into a full
// FIFO is accepted only when a pop frees a slot in the same cycle.
module midi_fifo #(
    parameter int FIFO_AW = 3,
    parameter int DW      = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [DW-1:0]      din,
    output logic [DW-1:0]      dout,
    output logic [FIFO_AW:0]   count,
    output logic               full,
    output logic               empty
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};

    logic [DW-1:0]      mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               do_push, do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & ~flush & (~full | do_pop);
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Next pointer/count values; pointers wrap naturally modulo depth
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since occupancy gates reads
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/midi_rx_fifo.sv
// MIDI serial receiver (8N1, LSB first) feeding a byte FIFO that the host
// drains through a DATA/STATUS register window, with an active-low IRQ.
module midi_rx_fifo
    import vicmidi_pkg::*;
#(
    parameter int CLKS_PER_BIT = 32,
    parameter int FIFO_AW      = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rxd,
    input  logic       sel,
    input  logic       r_w,
    input  logic       addr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       irq_n,
    output logic       rx_led
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_C = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_C = CW'(CLKS_PER_BIT / 2 - 1);

    // Status count field is 3 bits wide; a full FIFO reads as 7
    function automatic logic [2:0] sat_count3(input logic [FIFO_AW:0] cnt);
        if (cnt > (FIFO_AW+1)'(7)) return 3'd7;
        return cnt[2:0];
    endfunction

    rx_state_e        state_q, state_d;
    logic [CW-1:0]    clkcnt_q, clkcnt_d;
    logic [2:0]       bitcnt_q, bitcnt_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             rx_meta_q, rxs_q;
    logic             rx_push, ferr_set;

    logic             rd_act_q, wr_act_q;
    logic             rd_now, wr_now;
    logic [3:0]       wr_ctrl_q;        // {ien, flush, clr_ferr, clr_ovr}
    logic             pop, commit, flush;
    logic             ien_q, ovr_q, ferr_q;
    logic             irq_n_q, rx_led_q;

    logic [7:0]       fifo_dout;
    logic [FIFO_AW:0] fifo_count;
    logic             fifo_full, fifo_empty;
    logic [7:0]       status;
    logic             unused_data_in;

    assign unused_data_in = ^{data_in[5:4], data_in[1:0]};

    // Two-flop synchroniser for the asynchronous serial line
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rxd;
            rxs_q     <= rx_meta_q;
        end
    end

    // Receiver FSM state and counters
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            clkcnt_q <= '0;
            bitcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            clkcnt_q <= clkcnt_d;
            bitcnt_q <= bitcnt_d;
        end
    end

    // Shift register is pure data, always fully rewritten before a push
    always_ff @(posedge clock) begin
        shreg_q <= shreg_d;
    end

    // Receiver next-state: half-bit check of the start bit, then centred sampling
    always_comb begin
        state_d  = state_q;
        clkcnt_d = clkcnt_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        rx_push  = 1'b0;
        ferr_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rxs_q) begin
                    state_d  = ST_START;
                    clkcnt_d = '0;
                    bitcnt_d = '0;
                end
            end
            ST_START: begin
                if (clkcnt_q == HALF_C) begin
                    clkcnt_d = '0;
                    state_d  = rxs_q ? ST_IDLE : ST_DATA;
                end else begin
                    clkcnt_d = clkcnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (clkcnt_q == LAST_C) begin
                    clkcnt_d          = '0;
                    shreg_d[bitcnt_q] = rxs_q;
                    if (bitcnt_q == 3'd7) state_d  = ST_STOP;
                    else                  bitcnt_d = bitcnt_q + 1'b1;
                end else begin
                    clkcnt_d = clkcnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (clkcnt_q == LAST_C) begin
                    clkcnt_d = '0;
                    if (rxs_q) begin
                        rx_push = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_d  = ST_BREAK;
                    end
                end else begin
                    clkcnt_d = clkcnt_q + 1'b1;
                end
            end
            ST_BREAK: begin
                if (rxs_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus access decode: pop and control commit fire when the access ends
    assign rd_now  = sel & r_w & (addr == REG_DATA);
    assign wr_now  = sel & ~r_w & (addr == REG_STAT);
    assign pop     = rd_act_q & ~rd_now;
    assign commit  = wr_act_q & ~wr_now;
    assign flush   = commit & wr_ctrl_q[2];
    assign data_oe = sel & r_w;

    // Remember whether the previous cycle was inside a DATA read / CONTROL write
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_act_q <= 1'b0;
            wr_act_q <= 1'b0;
        end else begin
            rd_act_q <= rd_now;
            wr_act_q <= wr_now;
        end
    end

    // Capture the control bits while the write is held on the bus
    always_ff @(posedge clock) begin
        if (wr_now) wr_ctrl_q <= {data_in[CTRL_IEN], data_in[CTRL_FLUSH],
                                  data_in[CTRL_CLR_FERR], data_in[CTRL_CLR_OVR]};
    end

    // Sticky error flags and interrupt enable; a new error beats a clear
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ien_q  <= 1'b0;
            ovr_q  <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            if (commit) ien_q <= wr_ctrl_q[3];
            if (rx_push & fifo_full & ~pop & ~flush) ovr_q <= 1'b1;
            else if (commit & wr_ctrl_q[0])          ovr_q <= 1'b0;
            if (ferr_set)                            ferr_q <= 1'b1;
            else if (commit & wr_ctrl_q[1])          ferr_q <= 1'b0;
        end
    end

    midi_fifo #(
        .FIFO_AW (FIFO_AW),
        .DW      (8)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (rx_push),
        .pop   (pop),
        .flush (flush),
        .din   (shreg_q),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Status byte and read mux; bus data is zero whenever not driving
    always_comb begin
        status                       = '0;
        status[STAT_IEN]             = ien_q;
        status[STAT_CNT_LSB +: 3]    = sat_count3(fifo_count);
        status[STAT_FERR]            = ferr_q;
        status[STAT_OVR]             = ovr_q;
        status[STAT_FULL]            = fifo_full;
        status[STAT_NE]              = ~fifo_empty;
        data_out = 8'h00;
        if (sel & r_w) begin
            if (addr == REG_DATA) data_out = fifo_empty ? 8'h00 : fifo_dout;
            else                  data_out = status;
        end
    end

    // Registered interrupt and activity indicator
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            irq_n_q  <= 1'b1;
            rx_led_q <= 1'b0;
        end else begin
            irq_n_q  <= ~(ien_q & (~fifo_empty | ovr_q | ferr_q));
            rx_led_q <= (state_q != ST_IDLE);
        end
    end

    assign irq_n  = irq_n_q;
    assign rx_led = rx_led_q;

endmodule
